// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-latched requests, fixed-priority arbitration,
// PC redirect to a fixed vector and register-bank select for the service routine.
module intr_ctrl #(
    parameter int unsigned N_SRC  = 4,
    parameter logic [7:0]  VECTOR = 8'h04
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] irq,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             gie_we,
    input  logic             gie_wdata,
    input  logic [7:0]       pc,
    input  logic             instr_boundary,
    input  logic             reti,
    output logic             intr_en,
    output logic             pc_load,
    output logic [7:0]       pc_target,
    output logic [1:0]       cause,
    output logic [N_SRC-1:0] pending
);

    localparam int unsigned PC_W    = 8;
    localparam int unsigned CAUSE_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        SERVICE = 2'd2,
        EXIT    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               intr_en_q, intr_en_d;
    logic               pc_load_q, pc_load_d;
    logic [PC_W-1:0]    pc_target_q, pc_target_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic               gie_q, gie_d;
    logic [PC_W-1:0]    epc_q, epc_d;
    logic [N_SRC-1:0]   irq_q, irq_d;

    logic [N_SRC-1:0]   req_c;
    logic [N_SRC-1:0]   clr_c;
    logic [CAUSE_W-1:0] winner_c;
    logic               take_c;

    // Lowest enabled pending index wins; scanning downward leaves the lowest last.
    always_comb begin
        req_c    = pending_q & mask_q;
        winner_c = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (req_c[i]) begin
                winner_c = CAUSE_W'(i);
            end
        end
        take_c = (state_q == IDLE) & gie_q & instr_boundary & (|req_c);
        clr_c  = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            clr_c[i] = take_c & (winner_c == CAUSE_W'(i));
        end
    end

    // Next-state and registered outputs; a new edge beats the take-clear.
    always_comb begin
        state_d     = state_q;
        intr_en_d   = intr_en_q;
        pc_load_d   = 1'b0;
        pc_target_d = pc_target_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        irq_d       = irq;
        pending_d   = (pending_q & ~clr_c) | (irq & ~irq_q);
        mask_d      = mask_we ? mask_wdata : mask_q;
        gie_d       = gie_we ? gie_wdata : gie_q;

        case (state_q)
            IDLE: begin
                intr_en_d = 1'b0;
                if (take_c) begin
                    state_d     = ENTER;
                    epc_d       = pc;
                    cause_d     = winner_c;
                    pc_load_d   = 1'b1;
                    pc_target_d = VECTOR;
                    intr_en_d   = 1'b1;
                end
            end
            ENTER: begin
                state_d   = SERVICE;
                intr_en_d = 1'b1;
            end
            SERVICE: begin
                intr_en_d = 1'b1;
                if (reti) begin
                    state_d     = EXIT;
                    pc_load_d   = 1'b1;
                    pc_target_d = epc_q;
                end
            end
            EXIT: begin
                state_d   = IDLE;
                intr_en_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                intr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            intr_en_q   <= 1'b0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
            cause_q     <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            gie_q       <= 1'b0;
            epc_q       <= '0;
            irq_q       <= '0;
        end else begin
            state_q     <= state_d;
            intr_en_q   <= intr_en_d;
            pc_load_q   <= pc_load_d;
            pc_target_q <= pc_target_d;
            cause_q     <= cause_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            gie_q       <= gie_d;
            epc_q       <= epc_d;
            irq_q       <= irq_d;
        end
    end

    assign intr_en   = intr_en_q;
    assign pc_load   = pc_load_q;
    assign pc_target = pc_target_q;
    assign cause     = cause_q;
    assign pending   = pending_q;

endmodule
